// File: rtl/counter_capture.sv
// Shared up/down ramp counter with per-channel first-edge capture for a
// single-slope ADC column readout. Handshake is start/busy/done.
module counter_capture #(
   parameter int WIDTH    = 8,
   parameter int NCH      = 4,
   parameter int SATURATE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 dir,
   input  logic [WIDTH-1:0]     setval,
   input  logic [WIDTH-1:0]     limit,
   input  logic [NCH-1:0]       cmp,
   output logic [WIDTH-1:0]     count,
   output logic [NCH*WIDTH-1:0] capt,
   output logic [NCH-1:0]       capt_vld,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow,
   output logic [1:0]           dbg_state
);

   // Handshake: start is a one-cycle request taken only in IDLE; busy is
   // high for every RUN cycle; done pulses for exactly one cycle afterwards.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       count_q, count_d;
   logic [WIDTH-1:0]       limit_q, limit_d;
   logic                   dir_q, dir_d;
   logic [NCH*WIDTH-1:0]   capt_q, capt_d;
   logic [NCH-1:0]         vld_q, vld_d;
   logic [NCH-1:0]         hist_q, hist_d;
   logic [NCH-1:0]         trip;
   logic                   ovf_q, ovf_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      limit_d = limit_q;
      dir_d   = dir_q;
      capt_d  = capt_q;
      vld_d   = vld_q;
      ovf_d   = ovf_q;
      hist_d  = cmp;
      trip    = '0;

      if (state_q == S_RUN) begin
         trip = cmp & ~hist_q & ~vld_q;
      end
      for (int i = 0; i < NCH; i++) begin
         if (trip[i]) begin
            capt_d[i*WIDTH +: WIDTH] = count_q;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               count_d = setval;
               dir_d   = dir;
               limit_d = limit;
               vld_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            vld_d = vld_q | trip;
            // The terminating cycle takes its captures but does not step.
            if ((count_q == limit_q) || (&vld_d)) begin
               state_d = S_DONE;
            end else if (!dir_q) begin
               if (count_q == ALL_ONES) begin
                  ovf_d   = 1'b1;
                  count_d = (SATURATE != 0) ? ALL_ONES : ZERO;
               end else begin
                  count_d = count_q + ONE;
               end
            end else begin
               if (count_q == ZERO) begin
                  ovf_d   = 1'b1;
                  count_d = (SATURATE != 0) ? ZERO : ALL_ONES;
               end else begin
                  count_d = count_q - ONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         limit_q <= '0;
         dir_q   <= 1'b0;
         capt_q  <= '0;
         vld_q   <= '0;
         hist_q  <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         limit_q <= limit_d;
         dir_q   <= dir_d;
         capt_q  <= capt_d;
         vld_q   <= vld_d;
         hist_q  <= hist_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign count     = count_q;
   assign capt      = capt_q;
   assign capt_vld  = vld_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_capture.sv
// Bench for counter_capture: a wrapping and a saturating instance share the
// same stimulus and are each compared every cycle against a ramp model.
module tb_counter_capture;

   logic       clk;
   logic       rst;
   logic       start;
   logic       dir;
   logic [7:0] setval;
   logic [7:0] limit;
   logic [3:0] cmp;

   // index 0 = wrapping instance, index 1 = saturating instance
   logic [1:0][7:0]  d_count;
   logic [1:0][31:0] d_capt;
   logic [1:0][3:0]  d_vld;
   logic [1:0]       d_busy;
   logic [1:0]       d_done;
   logic [1:0]       d_ovf;
   logic [1:0][1:0]  d_state;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   counter_capture #(.WIDTH(8), .NCH(4), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst), .start(start), .dir(dir), .setval(setval),
      .limit(limit), .cmp(cmp), .count(d_count[0]), .capt(d_capt[0]),
      .capt_vld(d_vld[0]), .busy(d_busy[0]), .done(d_done[0]),
      .overflow(d_ovf[0]), .dbg_state(d_state[0])
   );

   counter_capture #(.WIDTH(8), .NCH(4), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst), .start(start), .dir(dir), .setval(setval),
      .limit(limit), .cmp(cmp), .count(d_count[1]), .capt(d_capt[1]),
      .capt_vld(d_vld[1]), .busy(d_busy[1]), .done(d_done[1]),
      .overflow(d_ovf[1]), .dbg_state(d_state[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int d, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual %0h required %0h at %0t", name, d, act, exp, $time);
      end
   endtask

   // Ramp value in RUN cycle k is set+k or set-k; out-of-range values either
   // clamp or fold modulo 256, and having left the range marks overflow.
   function automatic int ramp_val(input int set, input int dn, input int k);
      return dn != 0 ? set - k : set + k;
   endfunction

   function automatic logic [7:0] ramp_count(input int v, input int sat);
      if (sat != 0) return (v > 255) ? 8'd255 : ((v < 0) ? 8'd0 : 8'(v));
      return 8'(v & 255);
   endfunction

   // model: phase 0 idle, 1 run, 2 done
   int         m_phase [2];
   int         m_k     [2];
   int         m_set   [2];
   int         m_dir   [2];
   logic [7:0] m_lim   [2];
   logic [7:0] m_count [2];
   logic [7:0] m_capt  [2][4];
   logic [3:0] m_vld   [2];
   logic       m_ovf   [2];
   logic [3:0] m_prev;

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_phase[d] = 0;
            m_count[d] = 8'd0;
            m_vld[d]   = 4'd0;
            m_ovf[d]   = 1'b0;
            for (int i = 0; i < 4; i++) m_capt[d][i] = 8'd0;
         end else begin
            case (m_phase[d])
               0: if (start) begin
                  m_set[d]   = int'(setval);
                  m_dir[d]   = int'(dir);
                  m_lim[d]   = limit;
                  m_k[d]     = 0;
                  m_count[d] = setval;
                  m_vld[d]   = 4'd0;
                  m_ovf[d]   = 1'b0;
                  m_phase[d] = 1;
               end
               1: begin
                  for (int i = 0; i < 4; i++) begin
                     if (cmp[i] && !m_prev[i] && !m_vld[d][i]) begin
                        m_capt[d][i] = m_count[d];
                        m_vld[d][i]  = 1'b1;
                     end
                  end
                  if (m_count[d] == m_lim[d] || m_vld[d] == 4'hF) begin
                     m_phase[d] = 2;
                  end else begin
                     int v;
                     m_k[d]++;
                     v = ramp_val(m_set[d], m_dir[d], m_k[d]);
                     m_count[d] = ramp_count(v, d);
                     m_ovf[d]   = (v > 255) || (v < 0);
                  end
               end
               default: m_phase[d] = 0;
            endcase
         end
      end
      m_prev = rst ? 4'd0 : cmp;
   end

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            logic [31:0] ec;
            for (int i = 0; i < 4; i++) ec[i*8 +: 8] = m_capt[d][i];
            chk("count",    d, 32'(d_count[d]), 32'(m_count[d]));
            chk("capt",     d, d_capt[d],       ec);
            chk("capt_vld", d, 32'(d_vld[d]),   32'(m_vld[d]));
            chk("busy",     d, 32'(d_busy[d]),  32'(m_phase[d] == 1));
            chk("done",     d, 32'(d_done[d]),  32'(m_phase[d] == 2));
            chk("overflow", d, 32'(d_ovf[d]),   32'(m_ovf[d]));
            chk("state",    d, 32'(d_state[d]), 32'(m_phase[d]));
         end
      end
   end

   task automatic do_start(input logic dn, input logic [7:0] sv, input logic [7:0] lm);
      start  = 1'b1;
      dir    = dn;
      setval = sv;
      limit  = lm;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int busy_cnt;
   int done_cnt;

   initial begin
      rst = 1'b1; start = 1'b0; dir = 1'b0; setval = 8'd0; limit = 8'd0; cmp = 4'd0;
      idle(2);
      chk_en = 1'b1;
      chk("reset_state", 1, 32'(d_state[1]), 32'd0);
      chk("reset_count", 1, 32'(d_count[1]), 32'd0);
      rst = 1'b0;
      idle(2);

      // reset mid-run at count 37
      do_start(1'b0, 8'd0, 8'd200);
      idle(37);
      chk("pre_rst_count", 1, 32'(d_count[1]), 32'd37);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("rst_state", 1, 32'(d_state[1]), 32'd0);
      chk("rst_count", 1, 32'(d_count[1]), 32'd0);
      chk("rst_busy",  1, 32'(d_busy[1]),  32'd0);
      chk("rst_done",  1, 32'(d_done[1]),  32'd0);
      chk("rst_vld",   1, 32'(d_vld[1]),   32'd0);
      chk("rst_ovf",   1, 32'(d_ovf[1]),   32'd0);
      idle(2);

      // up-ramp 10..50 with captures at 20 and 35
      busy_cnt = 0;
      done_cnt = 0;
      do_start(1'b0, 8'd10, 8'd50);
      for (int k = 0; k < 50; k++) begin
         if (k == 10) cmp[0] = 1'b1;
         if (k == 25) cmp[2] = 1'b1;
         busy_cnt += int'(d_busy[1]);
         done_cnt += int'(d_done[1]);
         @(negedge clk);
      end
      chk("up_capt0",  1, 32'(d_capt[1][7:0]),   32'd20);
      chk("up_capt2",  1, 32'(d_capt[1][23:16]), 32'd35);
      chk("up_vld",    1, 32'(d_vld[1]),         32'b0101);
      chk("up_busy_n", 1, 32'(busy_cnt),         32'd41);
      chk("up_done_n", 1, 32'(done_cnt),         32'd1);
      cmp = 4'd0;
      idle(3);

      // early finish when all channels rise at 3,4,5,6
      do_start(1'b0, 8'd0, 8'd255);
      for (int k = 0; k < 12; k++) begin
         if (k >= 3 && k <= 6) cmp[k-3] = 1'b1;
         if (k == 7) chk("early_done", 1, 32'(d_done[1]), 32'd1);
         @(negedge clk);
      end
      chk("early_count", 1, 32'(d_count[1]),       32'd6);
      chk("early_vld",   1, 32'(d_vld[1]),         32'hF);
      chk("early_capt1", 1, 32'(d_capt[1][15:8]),  32'd4);
      cmp = 4'd0;
      idle(3);

      // down-count from 2 toward 250
      do_start(1'b1, 8'd2, 8'd250);
      for (int k = 0; k < 16; k++) begin
         if (k == 2) chk("dn_ovf_k2", 0, 32'(d_ovf[0]), 32'd0);
         if (k == 3) begin
            chk("dn_wrap_255", 0, 32'(d_count[0]), 32'd255);
            chk("dn_wrap_ovf", 0, 32'(d_ovf[0]),   32'd1);
            chk("dn_sat_0",    1, 32'(d_count[1]), 32'd0);
            chk("dn_sat_ovf",  1, 32'(d_ovf[1]),   32'd1);
         end
         if (k == 12) cmp = 4'hF;
         @(negedge clk);
      end
      chk("dn_wrap_end", 0, 32'(d_count[0]), 32'd250);
      chk("dn_sat_end",  1, 32'(d_count[1]), 32'd0);
      chk("dn_wrap_vld", 0, 32'(d_vld[0]),   32'd0);
      chk("dn_sat_vld",  1, 32'(d_vld[1]),   32'hF);
      cmp = 4'd0;
      idle(3);

      // saturating up-count from 253 with an unreachable limit
      done_cnt = 0;
      do_start(1'b0, 8'd253, 8'd10);
      for (int k = 0; k < 25; k++) begin
         if (k == 4) begin
            cmp[3] = 1'b1;
            chk("sat_k4_count", 1, 32'(d_count[1]), 32'd255);
            chk("sat_k4_ovf",   1, 32'(d_ovf[1]),   32'd1);
         end
         if (k == 20) cmp = 4'hF;
         if (k < 20) done_cnt += int'(d_done[1]);
         @(negedge clk);
      end
      chk("sat_capt3",    1, 32'(d_capt[1][31:24]), 32'd255);
      chk("sat_no_done",  1, 32'(done_cnt),         32'd0);
      chk("sat_ovf",      1, 32'(d_ovf[1]),         32'd1);
      chk("wrap_capt3",   0, 32'(d_capt[0][31:24]), 32'd1);
      chk("wrap_vld",     0, 32'(d_vld[0]),         32'b1000);
      cmp = 4'd0;
      idle(3);

      // repeat edges, ignored starts, restart in the first IDLE cycle
      cmp = 4'b0001;
      idle(2);
      do_start(1'b0, 8'd100, 8'd120);
      for (int k = 0; k < 31; k++) begin
         cmp[1] = (k == 3) || (k == 6);
         start  = (k == 8) || (k == 21) || (k == 22);
         if (k == 8 || k == 21) setval = 8'd0;
         if (k == 22) begin
            setval = 8'd5;
            limit  = 8'd7;
         end
         if (k == 21) chk("rt_done", 1, 32'(d_done[1]), 32'd1);
         if (k == 22) begin
            chk("rt_capt1", 1, 32'(d_capt[1][15:8]), 32'd103);
            chk("rt_vld",   1, 32'(d_vld[1]),        32'b0010);
            chk("rt_count", 1, 32'(d_count[1]),      32'd120);
         end
         if (k == 23) begin
            chk("rt_restart_count", 1, 32'(d_count[1]), 32'd5);
            chk("rt_restart_busy",  1, 32'(d_busy[1]),  32'd1);
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("rt_final_count", 1, 32'(d_count[1]), 32'd7);
      cmp = 4'd0;
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_capture.md
# counter_capture

Multi-channel ramp counter with per-channel capture, the parametrised successor to the team's half-adder counter. It drives one shared WIDTH-bit ramp, up or down, from a programmable start value to a programmable limit. It latches the ramp value independently for each of NCH comparator channels on that channel's first rising edge. It sits between the single-slope ADC column comparators and the readout logic, and gives a start/busy/done handshake for one conversion.

## Interface
- WIDTH, 8: counter and capture width in bits (≥2).
- NCH, 4: number of comparator/capture channels (≥1).
- SATURATE, 1: 1 = clamp at range end; 0 = wrap modulo 2^WIDTH.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle conversion request; honoured only in IDLE.
- dir  in  1  0 = count up, 1 = count down; sampled with start.
- setval  in  WIDTH  initial count; sampled with start.
- limit  in  WIDTH  terminal count; sampled with start.
- cmp  in  NCH  comparator outputs, already synchronised to clk.
- count  out  WIDTH  live ramp value.
- capt  out  NCH*WIDTH  captured values; channel i at bits [i*WIDTH +: WIDTH].
- capt_vld  out  NCH  channel i has captured in this conversion.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on conversion end.
- overflow  out  1  sticky; range end crossed during this conversion.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE; count, capt, capt_vld, busy, done, overflow, and the internal cmp history all go to 0.
- IDLE:
  - count holds its value.
  - On start: count←setval; dir and limit are latched; capt_vld←0; overflow←0; busy←1; go to RUN.
  - capt keeps the previous results until that channel re-captures.
- RUN, each cycle:
  - Step: count←count+1 if dir=0, count−1 if dir=1.
  - Up-count at all-ones, or down-count at 0, is a range-end crossing. With SATURATE=1, count holds at the end value and overflow←1. With SATURATE=0, count wraps to 0 or all-ones and overflow←1.
  - start is ignored.
- Capture:
  - cmp history is registered every cycle in every state.
  - Channel i trips when cmp[i]=1, its registered history is 0, state is RUN, and capt_vld[i]=0.
  - On a trip: capt[i]←the count value present in that cycle (pre-step); capt_vld[i]←1.
  - Only the first trip counts. Later edges are ignored until the next start.
  - A channel that is already high at start never trips without a new rising edge.
- Termination from RUN to DONE, with no step that cycle:
  - Condition (a): count==limit in the current cycle, or
  - Condition (b): every channel is valid after this cycle's captures.
  - Captures in the terminating cycle are still taken.
  - count holds at its current value.
  - With SATURATE=1 and limit unreachable, count sits at the range end until all channels trip.
- DONE: lasts one cycle. done=1, busy=0, captures disabled; then go to IDLE.
- Untripped channels keep capt_vld=0 and their stale capt.
- rst asserted in any state aborts the conversion and applies reset values on the next edge.

## Timing
- start sampled at edge t: count=setval and busy=1 from t+1. In RUN cycle k (k=0 at t+1), count = setval±k (with wrap or saturate).
- A cmp[i] rising edge seen in RUN cycle k gives capt[i]=setval±k and capt_vld[i]=1 from the next cycle.
- count==limit in RUN cycle k: DONE (done=1, busy=0) in cycle k+1, IDLE in k+2. The earliest accepted restart is a start in cycle k+2.
- setval==limit: the first RUN cycle terminates, so the conversion lasts exactly 1 RUN cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset mid-RUN: WIDTH=8, start with setval=0, limit=200; assert rst at count=37. Required next cycle: state IDLE, count=0, busy=0, done=0, capt_vld=0, overflow=0.
- Up-ramp captures: setval=10, limit=50, dir=0; raise cmp[0] at count=20 and cmp[2] at count=35, leave others low. Required: capt[0]=20, capt[2]=35, capt_vld=4'b0101, done pulse exactly 1 cycle after count=50, busy high for 41 cycles.
- Early finish: all 4 channels rise at counts 3, 4, 5, 6 with limit=255. Required: done in the cycle after count=6, count holds 6, capt_vld=4'hF.
- Down-count with wrap: SATURATE=0, dir=1, setval=2, limit=250. Required: count sequence 2,1,0,255,254 and so on, overflow=1 from the cycle showing 255, termination at 250.
- Saturate: SATURATE=1, dir=0, setval=253, limit=10, cmp[3] rises 5 cycles after start. Required: count 253,254,255,255,255; overflow=1; capt[3]=255; no done until all channels are valid.
- Re-trigger and repeat edges: cmp[1] pulses twice in RUN, and start is pulsed during RUN and DONE. Required: capt[1] equals the value at the first edge, the mid-run starts are ignored, and a start in the first IDLE cycle after DONE is accepted.
